debug_ocimem_ctrl: RTL and testbench
====================================

Name: debug_ocimem_ctrl

Overview:
- Debug monitor memory controller sitting directly downstream of the JTAG debug slave wrapper.
- Consumes the sysclk-domain `jdo` word and the `take_action_ocimem_*` strobes. Owns a small on-chip monitor RAM plus a status register.
- Returns `MonDReg`, `monitor_ready` and `monitor_error` to the wrapper's TCK stage.
- Exposes an Avalon-MM slave so the CPU debug core can execute from and access the same RAM.

Parameters:
- ADDR_W, 8, word-address width of the monitor RAM (DEPTH = 2**ADDR_W words); legal range 4..16.
- INIT_FILE, "", optional RAM init file; empty means the RAM content is undefined.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- jdo  in  38  JTAG data word, valid while any strobe is high.
- take_action_ocimem_a  in  1  single-cycle pulse: load address (optional read, optional status clear).
- take_action_ocimem_b  in  1  single-cycle pulse: write `jdo[34:3]` at the current address, then post-increment.
- take_no_action_ocimem_a  in  1  single-cycle pulse: read at the current address, then post-increment.
- avs_address  in  ADDR_W+1  word address; value DEPTH selects the status register.
- avs_read  in  1  CPU read request.
- avs_write  in  1  CPU write request.
- avs_writedata  in  32  CPU write data.
- avs_byteenable  in  4  CPU byte lanes.
- avs_debugaccess  in  1  write permission qualifier.
- avs_readdata  out  32  CPU read data.
- avs_waitrequest  out  1  stalls the CPU access.
- MonDReg  out  32  last JTAG read data.
- monitor_ready  out  1  status bit 0.
- monitor_error  out  1  status bit 1.

Behaviour:
- Reset values: all outputs 0; MonAReg (internal, ADDR_W bits) 0; FSM in IDLE; pending flags 0. RAM content is not reset.
- RAM: single port, synchronous read with 1-cycle latency, byte-enable writes. MonAReg arithmetic is modulo DEPTH, so DEPTH-1 wraps to 0.
- FSM states:
  - IDLE to JRD when a read is required.
  - IDLE to CRD on a CPU read.
  - JRD returns to IDLE after 1 cycle.
  - CRD returns to IDLE after 1 cycle.
  - Writes complete in IDLE and cause no state change.
- JTAG priority: a JTAG strobe (live or pending) is serviced in IDLE before any CPU request. A CPU request seen in the same cycle gets `avs_waitrequest`=1.
- take_action_ocimem_a:
  - MonAReg <= `jdo[17+ADDR_W-1:17]`.
  - If `jdo[36]`=1, clear `monitor_ready` and `monitor_error` next cycle.
  - If `jdo[35]`=1, issue a RAM read at the new address: go to JRD, and `MonDReg` <= RAM data at the end of JRD (2 cycles after the strobe). MonAReg is not incremented.
- take_no_action_ocimem_a: read the RAM at MonAReg via JRD, update `MonDReg` 2 cycles after the strobe, then MonAReg <= MonAReg+1 at JRD exit.
- take_action_ocimem_b: write `jdo[34:3]` (all byte lanes) at MonAReg in the servicing IDLE cycle; MonAReg+1 on the next clock. `MonDReg` is unchanged.
- Strobe arriving outside IDLE (in JRD or CRD): latched into a one-entry pending register together with its `jdo` copy, and serviced on the next IDLE cycle. A second strobe while one is already pending is a protocol violation; the newer strobe overwrites the pending one (flag it with a simulation assertion).
- Simultaneous strobes in one cycle: priority is b, then a, then no_action_a. Lower-priority strobes are dropped (simulation assertion).
- CPU read, RAM address (avs_address < DEPTH):
  - IDLE with no JTAG work: cycle 1 `avs_waitrequest`=1 (state moves to CRD).
  - Cycle 2 (CRD): `avs_readdata` valid, `avs_waitrequest`=0.
  - `avs_readdata` holds its value until the next read completes.
- CPU read, status register (avs_address = DEPTH): same 2-cycle timing, returning {30'b0, monitor_error, monitor_ready}.
- CPU write, RAM address:
  - Completes in the accepting IDLE cycle with `avs_waitrequest`=0.
  - Byte lanes obey `avs_byteenable`.
  - If `avs_debugaccess`=0 the write is acknowledged but dropped.
- CPU write, status register: bit0=1 sets `monitor_ready`, bit1=1 sets `monitor_error`; 0 bits leave the flags unchanged.
- `avs_waitrequest` is combinational from state and inputs. It is 0 when no request is present.
- Reset asserted mid-operation: FSM to IDLE immediately, pending strobe discarded, outputs to reset values.

Test Plan:
1. Reset release, then take_action_ocimem_a with `jdo[24:17]`=8'h10 and `jdo[35]`=0; then take_action_ocimem_b with `jdo[34:3]`=32'hDEADBEEF -> RAM[0x10]=DEADBEEF, MonAReg=0x11.
2. take_action_ocimem_a with address 0x10 and `jdo[35]`=1 -> `MonDReg`=DEADBEEF exactly 2 clocks after the strobe; then take_no_action_ocimem_a -> `MonDReg`=RAM[0x10] and MonAReg=0x11.
3. MonAReg=0xFF, take_action_ocimem_b -> RAM[0xFF] written, MonAReg wraps to 0x00.
4. CPU read of address 0x10 issued in the same cycle as take_action_ocimem_b writing 32'h12345678 -> `avs_waitrequest` high until the JTAG write completes, then `avs_readdata`=12345678.
5. CPU writes 32'h3 to status address 0x100 with `avs_debugaccess`=1 -> `monitor_ready`=`monitor_error`=1; take_action_ocimem_a with `jdo[36]`=1 -> both 0 next cycle. CPU RAM write with `avs_debugaccess`=0 -> RAM unchanged.
6. take_no_action_ocimem_a pulsed during a CRD cycle -> serviced on the next IDLE cycle, `MonDReg` correct, no strobe lost; reset_n pulsed during JRD -> all outputs 0 immediately.

Source files
------------

// File: rtl/debug_ocimem_ctrl.sv
// Debug monitor memory controller: JTAG-side access to the on-chip monitor RAM
// and status register, plus an Avalon-MM slave port for the CPU debug core.
module debug_ocimem_ctrl #(
  parameter int unsigned ADDR_W    = 8,
  parameter              INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W:0]   avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic              avs_debugaccess,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, JRD, CRD} state_e;
  typedef enum logic [1:0] {CMD_NONE, CMD_WR, CMD_SET, CMD_RD} cmd_e;

  state_e            state_q, state_d;
  cmd_e              live_cmd, eff_cmd, pend_cmd_q, pend_cmd_d;
  logic [36:3]       eff_jdo, pend_jdo_q, pend_jdo_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d, jdo_addr, ram_addr;
  logic [31:0]       mon_d_q, mon_d_d, avs_hold_q, avs_hold_d;
  logic [31:0]       crd_data, ram_rdata_q, ram_wdata, status;
  logic              ready_q, ready_d, error_q, error_d, jrd_inc_q, jrd_inc_d;
  logic              crd_ram_q, crd_ram_d, crd_stat_q, crd_stat_d;
  logic              ram_we, is_ram, is_stat, cpu_req, unused_jdo;
  logic [3:0]        ram_be;
  logic [31:0]       mem [DEPTH];

  // Strobe priority: b, then a, then no_action_a.
  always_comb begin
    live_cmd = CMD_NONE;
    if (take_action_ocimem_b)         live_cmd = CMD_WR;
    else if (take_action_ocimem_a)    live_cmd = CMD_SET;
    else if (take_no_action_ocimem_a) live_cmd = CMD_RD;
  end

  assign eff_cmd    = (live_cmd != CMD_NONE) ? live_cmd : pend_cmd_q;
  assign eff_jdo    = (live_cmd != CMD_NONE) ? jdo[36:3] : pend_jdo_q;
  assign jdo_addr   = eff_jdo[17 +: ADDR_W];
  assign unused_jdo = ^{jdo[37], jdo[2:0]};

  assign is_ram  = ~avs_address[ADDR_W];
  assign is_stat = avs_address[ADDR_W] && (avs_address[ADDR_W-1:0] == '0);
  assign cpu_req = avs_read | avs_write;
  assign status  = {30'b0, error_q, ready_q};

  always_comb begin
    crd_data = '0;
    if (crd_ram_q)       crd_data = ram_rdata_q;
    else if (crd_stat_q) crd_data = status;
  end

  always_comb begin
    state_d         = state_q;
    pend_cmd_d      = pend_cmd_q;
    pend_jdo_d      = pend_jdo_q;
    mon_a_d         = mon_a_q;
    mon_d_d         = mon_d_q;
    ready_d         = ready_q;
    error_d         = error_q;
    jrd_inc_d       = jrd_inc_q;
    crd_ram_d       = crd_ram_q;
    crd_stat_d      = crd_stat_q;
    avs_hold_d      = avs_hold_q;
    ram_we          = 1'b0;
    ram_be          = '0;
    ram_wdata       = '0;
    ram_addr        = mon_a_q;
    avs_waitrequest = 1'b0;
    unique case (state_q)
      IDLE: begin
        pend_cmd_d = CMD_NONE;
        unique case (eff_cmd)
          CMD_WR: begin
            ram_we    = 1'b1;
            ram_be    = '1;
            ram_wdata = eff_jdo[34:3];
            mon_a_d   = mon_a_q + 1'b1;
          end
          CMD_SET: begin
            mon_a_d  = jdo_addr;
            ram_addr = jdo_addr;
            if (eff_jdo[36]) begin
              ready_d = 1'b0;
              error_d = 1'b0;
            end
            if (eff_jdo[35]) begin
              jrd_inc_d = 1'b0;
              state_d   = JRD;
            end
          end
          CMD_RD: begin
            jrd_inc_d = 1'b1;
            state_d   = JRD;
          end
          default: ;
        endcase
        if (eff_cmd != CMD_NONE) begin
          avs_waitrequest = cpu_req;
        end else if (avs_read) begin
          avs_waitrequest = 1'b1;
          ram_addr        = avs_address[ADDR_W-1:0];
          crd_ram_d       = is_ram;
          crd_stat_d      = is_stat;
          state_d         = CRD;
        end else if (avs_write && avs_debugaccess) begin
          if (is_ram) begin
            ram_we    = 1'b1;
            ram_be    = avs_byteenable;
            ram_wdata = avs_writedata;
            ram_addr  = avs_address[ADDR_W-1:0];
          end else if (is_stat && avs_byteenable[0]) begin
            ready_d = ready_q | avs_writedata[0];
            error_d = error_q | avs_writedata[1];
          end
        end
      end
      JRD, CRD: begin
        avs_waitrequest = (state_q == JRD) ? cpu_req : avs_write;
        if (state_q == JRD) begin
          mon_d_d = ram_rdata_q;
          if (jrd_inc_q) mon_a_d = mon_a_q + 1'b1;
        end else begin
          avs_hold_d = crd_data;
        end
        // Strobes arriving while busy wait here for the next IDLE cycle.
        if (live_cmd != CMD_NONE) begin
          pend_cmd_d = live_cmd;
          pend_jdo_d = jdo[36:3];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pend_cmd_q <= CMD_NONE;
      pend_jdo_q <= '0;
      mon_a_q    <= '0;
      mon_d_q    <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      jrd_inc_q  <= 1'b0;
      crd_ram_q  <= 1'b0;
      crd_stat_q <= 1'b0;
      avs_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_cmd_q <= pend_cmd_d;
      pend_jdo_q <= pend_jdo_d;
      mon_a_q    <= mon_a_d;
      mon_d_q    <= mon_d_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      jrd_inc_q  <= jrd_inc_d;
      crd_ram_q  <= crd_ram_d;
      crd_stat_q <= crd_stat_d;
      avs_hold_q <= avs_hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
    ram_rdata_q <= mem[ram_addr];
  end

  // Read data is live during CRD and held afterwards until the next CPU read.
  assign avs_readdata  = (state_q == CRD) ? crd_data : avs_hold_q;
  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

  a_single_strobe: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0({take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a}));
  a_no_pending_overwrite: assert property (@(posedge clk) disable iff (!reset_n)
    !((pend_cmd_q != CMD_NONE) && (live_cmd != CMD_NONE)));
endmodule

// File: tb/tb_debug_ocimem_ctrl.sv
// Self-checking bench for debug_ocimem_ctrl against a behavioural memory/status model.
module tb_debug_ocimem_ctrl;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W:0] STAT_ADDR = (ADDR_W+1)'(DEPTH);

  logic clk = 1'b0;
  logic reset_n;
  logic [37:0] jdo;
  logic take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [ADDR_W:0] avs_address;
  logic avs_read, avs_write, avs_debugaccess;
  logic [31:0] avs_writedata;
  logic [3:0] avs_byteenable;
  logic [31:0] avs_readdata, MonDReg;
  logic avs_waitrequest, monitor_ready, monitor_error;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [DEPTH];
  int unsigned mon_a_m;
  logic [31:0] mond_m;
  logic rdy_m, err_m;

  debug_ocimem_ctrl #(.ADDR_W(ADDR_W), .INIT_FILE("")) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_debugaccess(avs_debugaccess), .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] rnd_jdo();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[37:0];
  endfunction

  function automatic logic [37:0] jdo_a(input int unsigned addr, input bit rd, input bit clr);
    logic [37:0] j;
    j = rnd_jdo();
    j[17 +: ADDR_W] = ADDR_W'(addr);
    j[35] = rd;
    j[36] = clr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j = rnd_jdo();
    j[34:3] = d;
    return j;
  endfunction

  // kind: 0 = take_action_b, 1 = take_action_a, 2 = take_no_action_a
  task automatic pulse(input int kind, input logic [37:0] j);
    jdo = j;
    if (kind == 0) take_action_ocimem_b = 1'b1;
    else if (kind == 1) take_action_ocimem_a = 1'b1;
    else take_no_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic cpu_write(input logic [ADDR_W:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic dbg, output int unsigned waits);
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_debugaccess = dbg;
    avs_write = 1'b1; waits = 0;
    @(negedge clk);
    while (avs_waitrequest && waits < 8) begin waits++; @(negedge clk); end
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [ADDR_W:0] a, output logic [31:0] d, output int unsigned waits);
    avs_address = a; avs_read = 1'b1; waits = 0;
    @(negedge clk);
    while (avs_waitrequest && waits < 8) begin waits++; @(negedge clk); end
    d = avs_readdata;
    @(posedge clk); #1;
    avs_read = 1'b0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; jdo = '0;
    take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
    avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
    avs_byteenable = '0; avs_debugaccess = 0;
    mon_a_m = 0; mond_m = '0; rdy_m = 0; err_m = 0;
    #12;
    checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL reset_mondreg: got %h want 0", MonDReg); end
    checks++; if ({monitor_error, monitor_ready} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {monitor_error, monitor_ready}); end
    checks++; if (avs_readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h want 0", avs_readdata); end
    checks++; if (avs_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b want 0", avs_waitrequest); end
    checks++; if (dut.mon_a_q !== 8'h00) begin errors++; $display("FAIL reset_mona: got %h want 00", dut.mon_a_q); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_cpu_fill();
    int unsigned w;
    logic [31:0] d;
    for (int unsigned a = 0; a < DEPTH; a++) begin
      d = $urandom();
      cpu_write((ADDR_W+1)'(a), d, 4'hF, 1'b1, w);
      mem_m[a] = d;
      checks++; if (w != 0) begin errors++; $display("FAIL fill_wait: addr %0d got %0d waits want 0", a, w); end
    end
  endtask

  task automatic test_jtag_rw();
    pulse(1, jdo_a(32'h10, 1'b0, 1'b0)); mon_a_m = 32'h10;
    pulse(0, jdo_b(32'hDEADBEEF)); mem_m[32'h10] = 32'hDEADBEEF; mon_a_m = 32'h11;
    checks++; if (dut.mon_a_q !== 8'h11) begin errors++; $display("FAIL b_incr: got %h want 11", dut.mon_a_q); end
    checks++; if (MonDReg !== mond_m) begin errors++; $display("FAIL b_mondreg_unchanged: got %h want %h", MonDReg, mond_m); end
    pulse(1, jdo_a(32'h10, 1'b1, 1'b0)); mon_a_m = 32'h10;
    checks++; if (MonDReg !== mond_m) begin errors++; $display("FAIL a_read_early: got %h want %h", MonDReg, mond_m); end
    tick(); mond_m = 32'hDEADBEEF;
    checks++; if (MonDReg !== mond_m) begin errors++; $display("FAIL a_read_data: got %h want %h", MonDReg, mond_m); end
    checks++; if (dut.mon_a_q !== 8'h10) begin errors++; $display("FAIL a_read_noinc: got %h want 10", dut.mon_a_q); end
    pulse(2, rnd_jdo());
    tick(); mond_m = mem_m[32'h10]; mon_a_m = 32'h11;
    checks++; if (MonDReg !== mond_m) begin errors++; $display("FAIL na_read_data: got %h want %h", MonDReg, mond_m); end
    checks++; if (dut.mon_a_q !== 8'h11) begin errors++; $display("FAIL na_read_inc: got %h want 11", dut.mon_a_q); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    d = $urandom();
    pulse(1, jdo_a(DEPTH-1, 1'b0, 1'b0));
    pulse(0, jdo_b(d)); mem_m[DEPTH-1] = d; mon_a_m = 0;
    checks++; if (dut.mon_a_q !== 8'h00) begin errors++; $display("FAIL wrap_mona: got %h want 00", dut.mon_a_q); end
    pulse(1, jdo_a(DEPTH-1, 1'b1, 1'b0)); tick();
    mon_a_m = DEPTH-1; mond_m = d;
    checks++; if (MonDReg !== mond_m) begin errors++; $display("FAIL wrap_data: got %h want %h", MonDReg, mond_m); end
  endtask

  task automatic test_random_jtag();
    int unsigned op, a;
    bit rd;
    logic [31:0] d;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        d = $urandom();
        pulse(0, jdo_b(d));
        mem_m[mon_a_m] = d; mon_a_m = (mon_a_m + 1) % DEPTH;
      end else if (op == 1) begin
        a = $urandom_range(0, DEPTH-1); rd = 1'($urandom_range(0, 1));
        pulse(1, jdo_a(a, rd, 1'b0));
        mon_a_m = a;
        if (rd) begin mond_m = mem_m[a]; tick(); end
      end else begin
        pulse(2, rnd_jdo());
        mond_m = mem_m[mon_a_m]; mon_a_m = (mon_a_m + 1) % DEPTH;
        tick();
      end
      checks++; if (MonDReg !== mond_m) begin errors++; $display("FAIL rnd_jtag_data: iter %0d op %0d got %h want %h", i, op, MonDReg, mond_m); end
      checks++; if (dut.mon_a_q !== 8'(mon_a_m)) begin errors++; $display("FAIL rnd_jtag_addr: iter %0d got %h want %h", i, dut.mon_a_q, 8'(mon_a_m)); end
    end
  endtask

  task automatic test_jtag_priority();
    int unsigned waits;
    logic [31:0] d;
    pulse(1, jdo_a(32'h10, 1'b0, 1'b0)); mon_a_m = 32'h10;
    avs_address = 9'h010; avs_read = 1'b1;
    jdo = jdo_b(32'h12345678); take_action_ocimem_b = 1'b1;
    waits = 0;
    @(negedge clk);
    checks++; if (avs_waitrequest !== 1'b1) begin errors++; $display("FAIL prio_wait: got %b want 1", avs_waitrequest); end
    if (avs_waitrequest) waits++;
    @(posedge clk); #1;
    take_action_ocimem_b = 1'b0;
    mem_m[32'h10] = 32'h12345678; mon_a_m = 32'h11;
    @(negedge clk);
    while (avs_waitrequest && waits < 8) begin waits++; @(negedge clk); end
    d = avs_readdata;
    @(posedge clk); #1;
    avs_read = 1'b0;
    checks++; if (waits != 2) begin errors++; $display("FAIL prio_latency: got %0d wait cycles want 2", waits); end
    checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL prio_data: got %h want 12345678", d); end
    tick(); tick();
    checks++; if (avs_readdata !== 32'h12345678) begin errors++; $display("FAIL prio_hold: got %h want 12345678", avs_readdata); end
  endtask

  task automatic test_status();
    int unsigned w;
    logic [31:0] d;
    cpu_write(STAT_ADDR, 32'h3, 4'hF, 1'b1, w); rdy_m = 1; err_m = 1;
    checks++; if (w != 0) begin errors++; $display("FAIL stat_wr_wait: got %0d want 0", w); end
    checks++; if ({monitor_error, monitor_ready} !== 2'b11) begin errors++; $display("FAIL stat_set: got %b want 11", {monitor_error, monitor_ready}); end
    cpu_write(STAT_ADDR, 32'h0, 4'hF, 1'b1, w);
    cpu_read(STAT_ADDR, d, w);
    checks++; if (d !== 32'h3 || w != 1) begin errors++; $display("FAIL stat_read: got %h/%0d want 00000003/1", d, w); end
    pulse(1, jdo_a($urandom_range(0, DEPTH-1), 1'b0, 1'b1)); rdy_m = 0; err_m = 0;
    mon_a_m = dut.mon_a_q;
    checks++; if ({monitor_error, monitor_ready} !== 2'b00) begin errors++; $display("FAIL stat_clear: got %b want 00", {monitor_error, monitor_ready}); end
    cpu_write(STAT_ADDR, 32'h2, 4'hF, 1'b1, w); err_m = 1;
    cpu_read(STAT_ADDR, d, w);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL stat_err_only: got %h want 00000002", d); end
    cpu_write(9'h020, ~mem_m[32'h20], 4'hF, 1'b0, w);
    checks++; if (w != 0) begin errors++; $display("FAIL nodbg_wait: got %0d want 0", w); end
    cpu_read(9'h020, d, w);
    checks++; if (d !== mem_m[32'h20]) begin errors++; $display("FAIL nodbg_drop: got %h want %h", d, mem_m[32'h20]); end
  endtask

  task automatic test_random_cpu();
    int unsigned a, w;
    logic [31:0] d, exp;
    logic [3:0] be;
    logic dbg;
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 9) == 0) ? DEPTH : $urandom_range(0, DEPTH-1);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom(); be = 4'($urandom_range(0, 15)); dbg = ($urandom_range(0, 3) != 0);
        cpu_write((ADDR_W+1)'(a), d, be, dbg, w);
        if (dbg) begin
          if (a < DEPTH) mem_m[a] = merge(mem_m[a], d, be);
          else if (be[0]) begin rdy_m = rdy_m | d[0]; err_m = err_m | d[1]; end
        end
        checks++; if (w != 0) begin errors++; $display("FAIL rnd_cpu_wr_wait: iter %0d got %0d want 0", i, w); end
      end else begin
        cpu_read((ADDR_W+1)'(a), d, w);
        exp = (a < DEPTH) ? mem_m[a] : {30'b0, err_m, rdy_m};
        checks++; if (d !== exp || w != 1) begin errors++; $display("FAIL rnd_cpu_rd: iter %0d addr %0d got %h/%0d want %h/1", i, a, d, w, exp); end
      end
    end
    checks++; if ({monitor_error, monitor_ready} !== {err_m, rdy_m}) begin errors++; $display("FAIL rnd_cpu_flags: got %b want %b", {monitor_error, monitor_ready}, {err_m, rdy_m}); end
  endtask

  task automatic test_pending();
    int unsigned x;
    x = $urandom_range(0, DEPTH-1);
    mon_a_m = $urandom_range(0, DEPTH-1);
    pulse(1, jdo_a(mon_a_m, 1'b0, 1'b0));
    avs_address = (ADDR_W+1)'(x); avs_read = 1'b1;
    @(negedge clk);
    checks++; if (avs_waitrequest !== 1'b1) begin errors++; $display("FAIL pend_accept_wait: got %b want 1", avs_waitrequest); end
    @(posedge clk); #1;
    take_no_action_ocimem_a = 1'b1; jdo = rnd_jdo();
    @(negedge clk);
    checks++; if (avs_waitrequest !== 1'b0 || avs_readdata !== mem_m[x]) begin errors++; $display("FAIL pend_crd: got %b/%h want 0/%h", avs_waitrequest, avs_readdata, mem_m[x]); end
    @(posedge clk); #1;
    avs_read = 1'b0; take_no_action_ocimem_a = 1'b0;
    checks++; if (MonDReg !== mond_m) begin errors++; $display("FAIL pend_early: got %h want %h", MonDReg, mond_m); end
    tick(); tick();
    mond_m = mem_m[mon_a_m]; mon_a_m = (mon_a_m + 1) % DEPTH;
    checks++; if (MonDReg !== mond_m) begin errors++; $display("FAIL pend_data: got %h want %h", MonDReg, mond_m); end
    checks++; if (dut.mon_a_q !== 8'(mon_a_m)) begin errors++; $display("FAIL pend_addr: got %h want %h", dut.mon_a_q, 8'(mon_a_m)); end
  endtask

  task automatic test_reset_mid();
    int unsigned y, w;
    logic [31:0] d;
    cpu_write(STAT_ADDR, 32'h3, 4'hF, 1'b1, w);
    y = $urandom_range(0, DEPTH-1);
    pulse(1, jdo_a(y, 1'b1, 1'b0));
    reset_n = 1'b0;
    #1;
    mon_a_m = 0; mond_m = '0; rdy_m = 0; err_m = 0;
    checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL rst_mid_mondreg: got %h want 0", MonDReg); end
    checks++; if ({monitor_error, monitor_ready} !== 2'b00) begin errors++; $display("FAIL rst_mid_flags: got %b want 00", {monitor_error, monitor_ready}); end
    checks++; if (avs_readdata !== 32'h0 || avs_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_mid_avs: got %h/%b want 0/0", avs_readdata, avs_waitrequest); end
    checks++; if (dut.mon_a_q !== 8'h00) begin errors++; $display("FAIL rst_mid_mona: got %h want 00", dut.mon_a_q); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick(); tick();
    checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL rst_mid_stale: got %h want 0", MonDReg); end
    cpu_read((ADDR_W+1)'(y), d, w);
    checks++; if (d !== mem_m[y] || w != 1) begin errors++; $display("FAIL rst_mid_ram: got %h/%0d want %h/1", d, w, mem_m[y]); end
  endtask

  initial begin
    test_reset();
    test_cpu_fill();
    test_jtag_rw();
    test_wrap();
    test_random_jtag();
    test_jtag_priority();
    test_status();
    test_random_cpu();
    test_pending();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
